// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory port A arbiter.
//   ADDR_W_DEF / DATA_W_DEF / BURST_MAX_DEF : default geometry
//   mem_req_t   : one requester's access (we, addr, wdata)
//   arb_state_t : arbitration FSM states
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF    = 20;
   localparam int unsigned DATA_W_DEF    = 144;
   localparam int unsigned BURST_MAX_DEF = 4;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_burst_arbiter.sv
// Two-way round-robin arbiter with bounded burst length.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : access requests (held until granted)
//   gnt[1:0] : one-hot grant, combinational from req and state
//   winner   : index of the granted requester (valid when |gnt)
module rr_burst_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       winner
);

   localparam int unsigned CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);

   arb_state_t    state;
   logic [CW-1:0] burst_cnt;
   logic          last_owner;
   logic          own;
   logic          keep;

   always_comb begin
      own    = 1'b0;
      keep   = 1'b0;
      winner = 1'b0;
      case (state)
         IDLE: winner = (&req) ? ~last_owner : req[1];
         OWN0, OWN1: begin
            own  = (state == OWN1);
            // owner keeps the port until its burst is spent, unless the other side is idle
            keep = req[own] && ((burst_cnt < CMAX) || !req[~own]);
            winner = keep ? own : ~own;
         end
         default: winner = 1'b0;
      endcase
      gnt = '0;
      if (!rst && (|req))
         gnt = winner ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
      end else if (|gnt) begin
         last_owner <= winner;
         state      <= winner ? OWN1 : OWN0;
         if (state == (winner ? OWN1 : OWN0)) begin
            if (burst_cnt != CMAX)
               burst_cnt <= burst_cnt + 1'b1;
         end else begin
            burst_cnt <= CW'(1);
         end
      end else begin
         state     <= IDLE;
         burst_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares data-memory port A between the vector core LSU (r0) and the loader DMA (r1).
//   clk, rst                       : clock, synchronous active-high reset
//   rX_req/we/addr/wdata           : requester access, held until rX_gnt
//   rX_gnt                         : access accepted this cycle
//   rX_rvalid/rX_rdata             : read return, one cycle after the grant
//   mem_write/mem_addr/mem_wdata   : memory port A drive (zero when idle)
//   mem_rdata                      : memory read data (1-cycle registered)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0] gnt;
   logic       winner;
   logic       any_gnt;
   logic       w_we;
   logic       rd_valid;
   logic       rd_tag;

   rr_burst_arbiter #(.BURST_MAX(BURST_MAX)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({r1_req, r0_req}),
      .gnt    (gnt),
      .winner (winner)
   );

   assign r0_gnt  = gnt[0];
   assign r1_gnt  = gnt[1];
   assign any_gnt = |gnt;
   assign w_we    = winner ? r1_we : r0_we;

   always_comb begin
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (any_gnt) begin
         mem_write = w_we;
         mem_addr  = winner ? r1_addr  : r0_addr;
         mem_wdata = winner ? r1_wdata : r0_wdata;
      end
   end

   // Tag follows the read through the memory's one-cycle latency; independent of the current grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_tag   <= 1'b0;
      end else begin
         rd_valid <= any_gnt & ~w_we;
         rd_tag   <= winner;
      end
   end

   assign r0_rvalid = rd_valid & ~rd_tag;
   assign r1_rvalid = rd_valid &  rd_tag;
   assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
   assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule
